arp_reply_tx: RTL and testbench

Generates a complete ARP reply frame on the GMII transmit interface whenever the receive path reports a valid ARP request addressed to this node. It sits directly downstream of the receive path's ARP parser (`arp_data_valid`, `rq_mac_s_addr`) and drives GMII TX bytes. The frame consists of preamble, SFD, Ethernet header, 28-byte ARP reply, zero padding to minimum length, and FCS, followed by the inter-frame gap. Output frames must pass the team's `fcs_rx` checker unmodified.

---
 rtl/eth_pkg.sv | 28 ++
 rtl/crc32_d8.sv | 21 ++
 rtl/arp_reply_tx.sv | 172 +++++++++++++++++
 tb/tb_arp_reply_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants and the transmit FSM state type used by the
// ARP reply generator and the receive-side FCS checker.
package eth_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE         = 8'h55;
   localparam logic [7:0]  SFD_BYTE              = 8'hD5;

   localparam logic [15:0] ETH_TYPE_ARP          = 16'h0806;
   localparam logic [15:0] ARP_HTYPE_ETH         = 16'h0001;
   localparam logic [15:0] ARP_PTYPE_IPV4        = 16'h0800;
   localparam logic [15:0] ARP_OPER_REPLY        = 16'h0002;
   localparam logic [7:0]  ARP_HLEN_ETH          = 8'h06;
   localparam logic [7:0]  ARP_PLEN_IPV4         = 8'h04;

   localparam int          ETH_MIN_PAYLOAD_BYTES = 60;

   localparam logic [31:0] CRC32_POLY_REFL       = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT            = 32'hFFFFFFFF;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_PREAMBLE,
      TX_DATA,
      TX_FCS,
      TX_IFG
   } tx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide next-state function of the reflected Ethernet CRC-32.
// Bits of the data byte are consumed LSB first, as they go on the wire.
module crc32_d8
   import eth_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   logic [31:0] c;

   always_comb begin
      c = crc_in ^ {24'h000000, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
      end
      crc_out = c;
   end

endmodule

// File: rtl/arp_reply_tx.sv
// ARP reply frame generator driving GMII TX: preamble, header, ARP body,
// zero padding and FCS, with a one-deep pending request and enforced IFG.
module arp_reply_tx
   import eth_pkg::*;
#(
   parameter int unsigned IFG_CYCLES = 12
)
(
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        arp_data_valid,
   input  logic [47:0] rq_mac_s_addr,
   input  logic [31:0] rq_ip_s_addr,
   input  logic [47:0] mac_s_addr,
   input  logic [31:0] ip_s_addr,
   output logic [7:0]  gmii_txd,
   output logic        gmii_tx_en,
   output logic        gmii_tx_er,
   output logic        busy,
   output logic        tx_done
);

   localparam int         HDR_BYTES = 42;
   localparam logic [6:0] PRE_LAST  = 7'd7;
   localparam logic [6:0] DATA_LAST = 7'(ETH_MIN_PAYLOAD_BYTES - 1);
   localparam logic [6:0] FCS_LAST  = 7'd3;
   localparam logic [6:0] IFG_LAST  = 7'(IFG_CYCLES - 1);

   tx_state_t   state_q;
   logic [6:0]  cnt_q;
   logic [31:0] crc_q;
   logic [31:0] crc_d;

   logic [47:0] rqMac_q;
   logic [31:0] rqIp_q;
   logic [47:0] locMac_q;
   logic [31:0] locIp_q;

   logic        pending_q;
   logic [47:0] pendRqMac_q;
   logic [31:0] pendRqIp_q;

   logic [7:0]  txd_q;
   logic        txEn_q;
   logic        busy_q;
   logic        txDone_q;

   logic [0:HDR_BYTES-1][7:0] hdrBytes;
   logic [3:0][7:0]           fcsBytes;
   logic [7:0]                dataByte;
   logic [7:0]                fcsByte;
   logic                      exitPoint;
   logic                      startNow;
   logic [47:0]               loadRqMac;
   logic [31:0]               loadRqIp;

   // Byte 0 of the frame sits at the MSB end of the packed header.
   assign hdrBytes = {rqMac_q, locMac_q, ETH_TYPE_ARP,
                      ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_HLEN_ETH, ARP_PLEN_IPV4,
                      ARP_OPER_REPLY, locMac_q, locIp_q, rqMac_q, rqIp_q};

   assign fcsBytes  = ~crc_q;
   assign dataByte  = (cnt_q < 7'(HDR_BYTES)) ? hdrBytes[cnt_q[5:0]] : 8'h00;
   assign fcsByte   = fcsBytes[cnt_q[1:0]];

   crc32_d8 u_crc (
      .crc_in  (crc_q),
      .data    (dataByte),
      .crc_out (crc_d)
   );

   // A new frame may start only from IDLE or on the final IFG cycle; a trigger
   // arriving then wins over an older pending request.
   assign exitPoint = (state_q == TX_IDLE) || ((state_q == TX_IFG) && (cnt_q == IFG_LAST));
   assign startNow  = exitPoint && (arp_data_valid || pending_q);
   assign loadRqMac = arp_data_valid ? rq_mac_s_addr : pendRqMac_q;
   assign loadRqIp  = arp_data_valid ? rq_ip_s_addr  : pendRqIp_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= TX_IDLE;
         cnt_q       <= '0;
         crc_q       <= CRC32_INIT;
         rqMac_q     <= '0;
         rqIp_q      <= '0;
         locMac_q    <= '0;
         locIp_q     <= '0;
         pending_q   <= 1'b0;
         pendRqMac_q <= '0;
         pendRqIp_q  <= '0;
         txd_q       <= 8'h00;
         txEn_q      <= 1'b0;
         busy_q      <= 1'b0;
         txDone_q    <= 1'b0;
      end else begin
         txd_q    <= 8'h00;
         txEn_q   <= 1'b0;
         txDone_q <= 1'b0;
         busy_q   <= (state_q != TX_IDLE);
         cnt_q    <= cnt_q + 7'd1;

         if (arp_data_valid && !exitPoint) begin
            pending_q   <= 1'b1;
            pendRqMac_q <= rq_mac_s_addr;
            pendRqIp_q  <= rq_ip_s_addr;
         end else if (startNow) begin
            pending_q   <= 1'b0;
         end

         if (startNow) begin
            rqMac_q  <= loadRqMac;
            rqIp_q   <= loadRqIp;
            locMac_q <= mac_s_addr;
            locIp_q  <= ip_s_addr;
            crc_q    <= CRC32_INIT;
            state_q  <= TX_PREAMBLE;
            cnt_q    <= '0;
         end

         case (state_q)
            TX_IDLE: begin
               if (!startNow) begin
                  cnt_q <= '0;
               end
            end
            TX_PREAMBLE: begin
               txd_q  <= (cnt_q == PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
               txEn_q <= 1'b1;
               if (cnt_q == PRE_LAST) begin
                  state_q <= TX_DATA;
                  cnt_q   <= '0;
               end
            end
            TX_DATA: begin
               txd_q  <= dataByte;
               txEn_q <= 1'b1;
               crc_q  <= crc_d;
               if (cnt_q == DATA_LAST) begin
                  state_q <= TX_FCS;
                  cnt_q   <= '0;
               end
            end
            TX_FCS: begin
               txd_q  <= fcsByte;
               txEn_q <= 1'b1;
               if (cnt_q == FCS_LAST) begin
                  state_q <= TX_IFG;
                  cnt_q   <= '0;
               end
            end
            TX_IFG: begin
               txDone_q <= (cnt_q == 7'd0);
               if ((cnt_q == IFG_LAST) && !startNow) begin
                  state_q <= TX_IDLE;
                  cnt_q   <= '0;
               end
            end
            default: begin
               state_q <= TX_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign gmii_txd   = txd_q;
   assign gmii_tx_en = txEn_q;
   assign gmii_tx_er = 1'b0;
   assign busy       = busy_q;
   assign tx_done    = txDone_q;

endmodule

// File: tb/tb_arp_reply_tx.sv
// Directed bench for arp_reply_tx: single reply, back-to-back, overwrite,
// reset mid-frame and a trigger on the last IFG cycle.
module tb_arp_reply_tx;

   localparam int LOG_DEPTH = 4096;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        arp_data_valid = 1'b0;
   logic [47:0] rq_mac_s_addr = '0;
   logic [31:0] rq_ip_s_addr = '0;
   logic [47:0] mac_s_addr = 48'h020000000001;
   logic [31:0] ip_s_addr = 32'hC0A8010A;
   logic [7:0]  gmii_txd;
   logic        gmii_tx_en;
   logic        gmii_tx_er;
   logic        busy;
   logic        tx_done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] txdLog  [0:LOG_DEPTH-1];
   logic       enLog   [0:LOG_DEPTH-1];
   logic       busyLog [0:LOG_DEPTH-1];
   logic       doneLog [0:LOG_DEPTH-1];
   logic [7:0] expFrame [0:59];

   arp_reply_tx #(.IFG_CYCLES(12)) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .arp_data_valid (arp_data_valid),
      .rq_mac_s_addr  (rq_mac_s_addr),
      .rq_ip_s_addr   (rq_ip_s_addr),
      .mac_s_addr     (mac_s_addr),
      .ip_s_addr      (ip_s_addr),
      .gmii_txd       (gmii_txd),
      .gmii_tx_en     (gmii_tx_en),
      .gmii_tx_er     (gmii_tx_er),
      .busy           (busy),
      .tx_done        (tx_done)
   );

   // Free-running clock; each rising edge gets a cycle number and its outputs
   // are logged 1 ns later so every check can refer to edge T+n directly.
   always #5 aclk = ~aclk;

   always @(posedge aclk) begin
      cyc = cyc + 1;
      #1;
      if (cyc < LOG_DEPTH) begin
         txdLog[cyc]  = gmii_txd;
         enLog[cyc]   = gmii_tx_en;
         busyLog[cyc] = busy;
         doneLog[cyc] = tx_done;
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bit-serial reflected CRC-32 reference.
   function automatic logic [31:0] crcStep(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      logic        fb;
      r = c;
      for (int b = 0; b < 8; b++) begin
         fb = r[0] ^ d[b];
         r  = r >> 1;
         if (fb) r = r ^ 32'hEDB88320;
      end
      return r;
   endfunction

   task automatic buildFrame(input logic [47:0] rqMac, input logic [31:0] rqIp,
                             input logic [47:0] locMac, input logic [31:0] locIp);
      for (int i = 0; i < 60; i++) expFrame[i] = 8'h00;
      for (int i = 0; i < 6; i++) begin
         expFrame[i]      = rqMac[47-8*i -: 8];
         expFrame[6+i]    = locMac[47-8*i -: 8];
         expFrame[22+i]   = locMac[47-8*i -: 8];
         expFrame[32+i]   = rqMac[47-8*i -: 8];
      end
      for (int i = 0; i < 4; i++) begin
         expFrame[28+i] = locIp[31-8*i -: 8];
         expFrame[38+i] = rqIp[31-8*i -: 8];
      end
      expFrame[12] = 8'h08; expFrame[13] = 8'h06;
      expFrame[14] = 8'h00; expFrame[15] = 8'h01;
      expFrame[16] = 8'h08; expFrame[17] = 8'h00;
      expFrame[18] = 8'h06; expFrame[19] = 8'h04;
      expFrame[20] = 8'h00; expFrame[21] = 8'h02;
   endtask

   // Checks a whole frame whose trigger was sampled at edge t.
   task automatic verifyFrame(input int t, input string tag);
      logic [31:0] crc;
      logic [31:0] fcs;
      int          cnt;
      for (int k = 0; k < 7; k++)
         checkOutput($sformatf("%s.pre%0d", tag, k), {24'h0, txdLog[t+1+k]}, 32'h55);
      checkOutput({tag, ".sfd"}, {24'h0, txdLog[t+8]}, 32'hD5);
      crc = 32'hFFFFFFFF;
      for (int i = 0; i < 60; i++) begin
         checkOutput($sformatf("%s.byte%0d", tag, i), {24'h0, txdLog[t+9+i]}, {24'h0, expFrame[i]});
         crc = crcStep(crc, expFrame[i]);
      end
      fcs = ~crc;
      for (int k = 0; k < 4; k++)
         checkOutput($sformatf("%s.fcs%0d", tag, k), {24'h0, txdLog[t+69+k]}, {24'h0, fcs[8*k +: 8]});
      crc = 32'hFFFFFFFF;
      for (int i = 0; i < 64; i++) crc = crcStep(crc, txdLog[t+9+i]);
      checkOutput({tag, ".residue"}, crc, 32'hDEBB20E3);
      cnt = 0;
      for (int i = 1; i <= 72; i++) cnt += int'(enLog[t+i] === 1'b1);
      checkOutput({tag, ".enHigh"}, cnt, 72);
      checkOutput({tag, ".enEnd"}, {31'h0, enLog[t+73]}, 32'h0);
      checkOutput({tag, ".doneAt73"}, {31'h0, doneLog[t+73]}, 32'h1);
      cnt = 0;
      for (int i = 1; i <= 84; i++) cnt += int'(doneLog[t+i] === 1'b1);
      checkOutput({tag, ".doneCount"}, cnt, 1);
      cnt = 0;
      for (int i = 1; i <= 84; i++) cnt += int'(busyLog[t+i] === 1'b1);
      checkOutput({tag, ".busyWindow"}, cnt, 84);
   endtask

   // Pulses the trigger so that it is sampled at edge `target` (or the next edge
   // if target is already past) and returns that edge number.
   task automatic applyStimulus(input int target, input logic [47:0] mac, input logic [31:0] ip,
                                output int t);
      @(negedge aclk);
      while (cyc < target - 1) @(negedge aclk);
      rq_mac_s_addr  = mac;
      rq_ip_s_addr   = ip;
      arp_data_valid = 1'b1;
      t = cyc + 1;
      @(negedge aclk);
      arp_data_valid = 1'b0;
      rq_mac_s_addr  = 48'hDEADBEEFCAFE;
      rq_ip_s_addr   = 32'h0BADF00D;
   endtask

   task automatic waitUntil(input int target);
      while (cyc < target) @(negedge aclk);
   endtask

   initial begin
      int t0, t1, t2, t3, t4, t5, tb2, tx, rel, cnt;

      repeat (3) @(negedge aclk);
      checkOutput("rst.txEn", {31'h0, gmii_tx_en}, 32'h0);
      checkOutput("rst.txd", {24'h0, gmii_txd}, 32'h0);
      checkOutput("rst.busy", {31'h0, busy}, 32'h0);
      checkOutput("rst.done", {31'h0, tx_done}, 32'h0);
      checkOutput("rst.txEr", {31'h0, gmii_tx_er}, 32'h0);
      aresetn = 1'b1;
      repeat (5) @(negedge aclk);

      $display("[TB] single reply");
      applyStimulus(0, 48'h112233445566, 32'hC0A80164, t0);
      waitUntil(t0 + 100);
      buildFrame(48'h112233445566, 32'hC0A80164, mac_s_addr, ip_s_addr);
      verifyFrame(t0, "single");
      checkOutput("single.dst0", {24'h0, txdLog[t0+9]}, 32'h11);
      checkOutput("single.type", {16'h0, txdLog[t0+21], txdLog[t0+22]}, 32'h0806);
      checkOutput("single.oper", {16'h0, txdLog[t0+29], txdLog[t0+30]}, 32'h0002);
      checkOutput("single.tpa", {txdLog[t0+47], txdLog[t0+48], txdLog[t0+49], txdLog[t0+50]}, 32'hC0A80164);
      checkOutput("single.sha0", {24'h0, txdLog[t0+31]}, 32'h02);
      checkOutput("single.spa", {txdLog[t0+37], txdLog[t0+38], txdLog[t0+39], txdLog[t0+40]}, 32'hC0A8010A);
      cnt = 0;
      for (int i = 42; i < 60; i++) cnt += int'(txdLog[t0+9+i] !== 8'h00);
      checkOutput("single.pad", cnt, 0);
      checkOutput("single.busyBefore", {31'h0, busyLog[t0]}, 32'h0);
      checkOutput("single.busyAfter", {31'h0, busyLog[t0+85]}, 32'h0);

      $display("[TB] back-to-back");
      applyStimulus(0, 48'h112233445566, 32'hC0A80164, t1);
      applyStimulus(t1 + 30, 48'hAABBCCDDEEFF, 32'hC0A80165, tx);
      waitUntil(t1 + 84 + 100);
      buildFrame(48'h112233445566, 32'hC0A80164, mac_s_addr, ip_s_addr);
      verifyFrame(t1, "b2b1");
      buildFrame(48'hAABBCCDDEEFF, 32'hC0A80165, mac_s_addr, ip_s_addr);
      verifyFrame(t1 + 84, "b2b2");
      checkOutput("b2b.dst0", {24'h0, txdLog[t1+84+9]}, 32'hAA);
      cnt = 0;
      for (int i = 73; i <= 84; i++) cnt += int'(enLog[t1+i] === 1'b0);
      checkOutput("b2b.idleGap", cnt, 12);
      checkOutput("b2b.start85", {31'h0, enLog[t1+85]}, 32'h1);

      $display("[TB] overwrite");
      applyStimulus(0, 48'h112233445566, 32'hC0A80164, t2);
      applyStimulus(t2 + 30, 48'hAABBCCDDEEFF, 32'hC0A80165, tx);
      applyStimulus(t2 + 40, 48'h0A0B0C0D0E0F, 32'hC0A80199, tx);
      waitUntil(t2 + 300);
      buildFrame(48'h0A0B0C0D0E0F, 32'hC0A80199, mac_s_addr, ip_s_addr);
      verifyFrame(t2 + 84, "ovr");
      cnt = 0;
      for (int i = 169; i <= 300; i++) cnt += int'(enLog[t2+i] === 1'b1);
      checkOutput("ovr.noThird", cnt, 0);
      checkOutput("ovr.busyEnd", {31'h0, busyLog[t2+169]}, 32'h0);

      $display("[TB] reset mid-frame");
      applyStimulus(0, 48'h112233445566, 32'hC0A80164, t3);
      waitUntil(t3 + 39);
      checkOutput("rstMid.enBefore", {31'h0, gmii_tx_en}, 32'h1);
      aresetn = 1'b0;
      #1;
      checkOutput("rstMid.en", {31'h0, gmii_tx_en}, 32'h0);
      checkOutput("rstMid.busy", {31'h0, busy}, 32'h0);
      checkOutput("rstMid.done", {31'h0, tx_done}, 32'h0);
      checkOutput("rstMid.txd", {24'h0, gmii_txd}, 32'h0);
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
      rel = cyc;
      waitUntil(rel + 101);
      cnt = 0;
      for (int i = 1; i <= 100; i++) cnt += int'(enLog[rel+i] === 1'b1) + int'(busyLog[rel+i] === 1'b1);
      checkOutput("rstMid.quiet", cnt, 0);
      applyStimulus(0, 48'h5A5A12345678, 32'h0A000001, t4);
      waitUntil(t4 + 100);
      buildFrame(48'h5A5A12345678, 32'h0A000001, mac_s_addr, ip_s_addr);
      verifyFrame(t4, "postRst");

      $display("[TB] boundary trigger");
      applyStimulus(0, 48'h112233445566, 32'hC0A80164, t5);
      applyStimulus(t5 + 84, 48'h665544332211, 32'hC0A80102, tx);
      waitUntil(t5 + 300);
      checkOutput("bnd.start", {31'h0, enLog[t5+85] | enLog[t5+86]}, 32'h1);
      tb2 = (enLog[t5+85] === 1'b1) ? t5 + 84 : t5 + 85;
      buildFrame(48'h665544332211, 32'hC0A80102, mac_s_addr, ip_s_addr);
      verifyFrame(tb2, "bnd");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
